// File: rtl/clock_monitor.sv
// clock_monitor: synchronizes clk_mon, emits edge pulses, measures its period in clk_in cycles
// and flags a stalled clk_mon.
module clock_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 clk_mon,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  output logic [CNT_WIDTH-1:0] edge_count,
  output logic                 timeout
);
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT);
  logic [SYNC_STAGES-1:0] sync;
  logic hist, have_ref, rise, fall, strobe;
  logic [CNT_WIDTH-1:0] cnt, idle, idle_next;
  always_comb begin
    rise = sync[SYNC_STAGES-1] & ~hist;
    fall = ~sync[SYNC_STAGES-1] & hist;
    strobe = rise & have_ref & ~timeout;
    idle_next = rise ? '0 : (idle == LIMIT ? idle : idle + 1'b1);
  end
  // cnt reads 1 in the rise_pulse cycle, so at the next rise it equals the distance.
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      cnt <= '0;
      idle <= '0;
      have_ref <= 1'b0;
      period <= '0;
      period_valid <= 1'b0;
      edge_count <= '0;
      timeout <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], clk_mon};
      hist <= sync[SYNC_STAGES-1];
      rise_pulse <= rise;
      fall_pulse <= fall;
      cnt <= rise ? CNT_WIDTH'(1) : cnt + 1'b1;
      period_valid <= strobe;
      if (strobe) period <= cnt;
      if (rise) have_ref <= 1'b1;
      if (rise) edge_count <= edge_count + 1'b1;
      idle <= idle_next;
      timeout <= idle_next == LIMIT;
    end
endmodule
